// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a single registered response slot. Optional perf counters: ALU_SHARE_PERF_EN.

module alu_share_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero_flag
);
    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b1110;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0110;

    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic [SHW-1:0]   w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;

    // Compares share the subtractor, so zero_flag reflects left-right for them.
    assign w_sub   = (i_op == OP_SUB) | (i_op == OP_SLT) | (i_op == OP_SLTU);
    assign w_sum   = w_sub ? (i_left - i_right) : (i_left + i_right);
    assign w_shamt = i_right[SHW-1:0];
    assign w_lt_s  = $signed(i_left) < $signed(i_right);
    assign w_lt_u  = i_left < i_right;

    assign o_zero_flag = (w_sum == '0);

    always_comb begin
        o_result = i_right;
        case (i_op)
            OP_ADD,
            OP_SUB:  o_result = w_sum;
            OP_AND:  o_result = i_left & i_right;
            OP_OR:   o_result = i_left | i_right;
            OP_XOR:  o_result = i_left ^ i_right;
            OP_SLL:  o_result = i_left << w_shamt;
            OP_SRL:  o_result = i_left >> w_shamt;
            OP_SRA:  o_result = $unsigned($signed(i_left) >>> w_shamt);
            OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt_s};
            OP_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_lt_u};
            default: o_result = i_right;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_left,
    input  logic [WIDTH-1:0] req0_right,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_left,
    input  logic [WIDTH-1:0] req1_right,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             stall_timeout
`ifdef ALU_SHARE_PERF_EN
    ,
    output logic [31:0]      perf_grant0,
    output logic [31:0]      perf_grant1,
    output logic [31:0]      perf_conflict
`endif
);
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    slot_state_e          r_state;
    slot_state_e          w_state_next;
    logic                 r_owner;
    logic                 r_rr_ptr;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic [TIMEOUT_W-1:0] r_hold;
    logic [TIMEOUT_W-1:0] w_hold_next;
    logic                 r_stall;

    logic                 w_full;
    logic                 w_owner_ready;
    logic                 w_drain;
    logic                 w_can_issue;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_issue;
    logic [3:0]           w_op;
    logic [WIDTH-1:0]     w_left;
    logic [WIDTH-1:0]     w_right;
    logic [WIDTH-1:0]     w_alu_result;
    logic                 w_alu_zero;

    assign w_full        = (r_state == S_FULL);
    assign w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;
    assign w_drain       = w_full & w_owner_ready;

    // rst_n gating keeps ready low while reset is held, even with the slot empty.
    assign w_can_issue = rst_n & (~w_full | w_drain);

    assign w_grant0 = req0_valid & (~req1_valid | ~r_rr_ptr);
    assign w_grant1 = req1_valid & (~req0_valid |  r_rr_ptr);
    assign w_issue  = w_can_issue & (w_grant0 | w_grant1);

    assign req0_ready = w_can_issue & w_grant0;
    assign req1_ready = w_can_issue & w_grant1;

    assign w_op    = w_grant1 ? req1_op    : req0_op;
    assign w_left  = w_grant1 ? req1_left  : req0_left;
    assign w_right = w_grant1 ? req1_right : req0_right;

    alu_share_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_op        (w_op),
        .i_left      (w_left),
        .i_right     (w_right),
        .o_result    (w_alu_result),
        .o_zero_flag (w_alu_zero)
    );

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Slot next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_issue) w_state_next = S_FULL;
            S_FULL:  if (w_drain && !w_issue) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    // Result slot, owner and round-robin pointer capture on grant only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (w_issue) begin
            r_owner  <= w_grant1;
            r_rr_ptr <= w_grant0;
            r_result <= w_alu_result;
            r_zero   <= w_alu_zero;
        end
    end

    // Hold watchdog: counts undrained FULL cycles, saturating.
    always_comb begin
        w_hold_next = r_hold;
        if (w_issue || w_drain) begin
            w_hold_next = '0;
        end else if (w_full && (r_hold != '1)) begin
            w_hold_next = r_hold + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold  <= '0;
            r_stall <= 1'b0;
        end else begin
            r_hold  <= w_hold_next;
            r_stall <= r_stall | (w_hold_next == '1);
        end
    end

    assign rsp0_valid    = w_full & ~r_owner;
    assign rsp1_valid    = w_full &  r_owner;
    assign rsp_result    = r_result;
    assign rsp_zero      = r_zero;
    assign stall_timeout = r_stall;

`ifdef ALU_SHARE_PERF_EN
    logic [31:0] r_perf_grant0;
    logic [31:0] r_perf_grant1;
    logic [31:0] r_perf_conflict;
    logic        w_conflict;

    assign w_conflict = req0_valid & req1_valid & w_can_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_grant0   <= '0;
            r_perf_grant1   <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (w_issue && w_grant0) r_perf_grant0 <= r_perf_grant0 + 32'd1;
            if (w_issue && w_grant1) r_perf_grant1 <= r_perf_grant1 + 32'd1;
            if (w_conflict)          r_perf_conflict <= r_perf_conflict + 32'd1;
        end
    end

    assign perf_grant0   = r_perf_grant0;
    assign perf_grant1   = r_perf_grant1;
    assign perf_conflict = r_perf_conflict;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed, table-driven bench for alu_share_arbiter plus multi-cycle corner sequences.

module tb_alu_share_arbiter;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b1110;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_left, req0_right, req1_left, req1_right;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, stall_timeout;
`ifdef ALU_SHARE_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_arbiter #(.WIDTH(32), .TIMEOUT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_op       (req0_op),
        .req0_left     (req0_left),
        .req0_right    (req0_right),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_op       (req1_op),
        .req1_left     (req1_left),
        .req1_right    (req1_right),
        .rsp0_valid    (rsp0_valid),
        .rsp0_ready    (rsp0_ready),
        .rsp1_valid    (rsp1_valid),
        .rsp1_ready    (rsp1_ready),
        .rsp_result    (rsp_result),
        .rsp_zero      (rsp_zero),
        .stall_timeout (stall_timeout)
`ifdef ALU_SHARE_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [3:0]  op0;
        logic [31:0] l0;
        logic [31:0] r0;
        logic        v1;
        logic [3:0]  op1;
        logic [31:0] l1;
        logic [31:0] r1;
        logic        rr0;
        logic        rr1;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_rv0;
        logic        e_rv1;
        logic [31:0] e_res;
        logic        chk_z;
        logic        e_z;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] op0, input logic [31:0] l0,
                         input logic [31:0] r0, input logic v1, input logic [3:0] op1,
                         input logic [31:0] l1, input logic [31:0] r1,
                         input logic rr0, input logic rr1);
        req0_valid = v0; req0_op = op0; req0_left = l0; req0_right = r0;
        req1_valid = v1; req1_op = op1; req1_left = l1; req1_right = r1;
        rsp0_ready = rr0; rsp1_ready = rr1;
    endtask

    initial begin
        // Rows run back to back from reset; expectations are the outputs seen
        // in that row's cycle, i.e. the slot filled by the previous row's grant.
        vecs[0]  = '{1'b1, OP_ADD, 32'd5, 32'd7,  1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, OP_ADD, 32'd0, 32'd0,  1'b1, OP_OR, 32'hF0, 32'h0F,
                     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd12, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, OP_SUB, 32'd3, 32'd3,  1'b1, OP_SLTU, 32'd1, 32'd2,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFF, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, OP_SUB, 32'd3, 32'd3,  1'b1, OP_SLTU, 32'd1, 32'd2,
                     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, OP_SUB, 32'd3, 32'd3,  1'b1, OP_SLTU, 32'd1, 32'd2,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, OP_SUB, 32'd3, 32'd3,  1'b1, OP_SLTU, 32'd1, 32'd2,
                     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, OP_ADD, 32'd0, 32'd0,  1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, OP_ADD, 32'd0, 32'd0,  1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, OP_ADD, 32'd0, 32'd0,  1'b1, OP_SLL, 32'd1, 32'd31,
                     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hF00FF00F, 1'b0, 1'b0};
        vecs[10] = '{1'b1, OP_SRL, 32'h80000000, 32'd31, 1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, OP_SLT, 32'hFFFFFFFF, 32'd1, 1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, OP_AND, 32'hF0F0, 32'hFF00, 1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, OP_PASS, 32'd5, 32'h1234, 1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hF000, 1'b0, 1'b0};
        vecs[14] = '{1'b1, OP_ADD, 32'hFFFFFFFF, 32'd1, 1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b0};
        vecs[15] = '{1'b0, OP_ADD, 32'd0, 32'd0,  1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, OP_ADD, 32'd0, 32'd0,  1'b0, OP_ADD, 32'd0, 32'd0,
                     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1};

        // Reset with req0 valid: ready must stay low while rst_n is low.
        rst_n = 1'b0;
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b1, 1'b1);
        #8;
        check("reset_req0_ready", 32'(req0_ready), 32'd0);
        check("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("reset_result", rsp_result, 32'd0);
        check("reset_zero", 32'(rsp_zero), 32'd0);
        check("reset_stall", 32'(stall_timeout), 32'd0);
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b1, 1'b1);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].v0, vecs[i].op0, vecs[i].l0, vecs[i].r0,
                  vecs[i].v1, vecs[i].op1, vecs[i].l1, vecs[i].r1,
                  vecs[i].rr0, vecs[i].rr1);
            #3;
            check($sformatf("vec%0d_req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_rdy0));
            check($sformatf("vec%0d_req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_rdy1));
            check($sformatf("vec%0d_rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].e_rv0));
            check($sformatf("vec%0d_rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].e_rv1));
            check($sformatf("vec%0d_result", i), rsp_result, vecs[i].e_res);
            if (vecs[i].chk_z)
                check($sformatf("vec%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].e_z));
            @(posedge clk); #1;
        end

        // Response backpressure on req1: slot holds, req0 waits, then issues on drain.
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1, OP_SRA, 32'h80000000, 32'd4, 1'b1, 1'b0);
        #3 check("sra_req1_ready", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b1, 1'b0);
            #3;
            check($sformatf("hold%0d_rsp1_valid", c), 32'(rsp1_valid), 32'd1);
            check($sformatf("hold%0d_result", c), rsp_result, 32'hF8000000);
            check($sformatf("hold%0d_req0_ready", c), 32'(req0_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp1_ready = 1'b1;
        #3;
        check("drain_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("drain_req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b1);
        #3;
        check("after_drain_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("after_drain_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("after_drain_result", rsp_result, 32'd2);

        // Watchdog: hold rsp0_ready low for 255 cycles.
        @(posedge clk); #1;
        drive(1'b1, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b1);
        // slot still owned by req0 from the previous issue: drain it first
        rsp0_ready = 1'b1;
        #3 check("wd_issue_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b1);
        check("wd_rsp0_valid", 32'(rsp0_valid), 32'd1);
        repeat (254) @(posedge clk);
        #1 check("wd_stall_254", 32'(stall_timeout), 32'd0);
        @(posedge clk); #1;
        check("wd_stall_255", 32'(stall_timeout), 32'd1);
        check("wd_still_valid", 32'(rsp0_valid), 32'd1);
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        check("wd_drained", 32'(rsp0_valid), 32'd0);
        check("wd_sticky", 32'(stall_timeout), 32'd1);

        // Asynchronous reset while FULL discards the slot.
        drive(1'b1, OP_ADD, 32'd2, 32'd3, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_rsp0_valid", 32'(rsp0_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("async_result", rsp_result, 32'd0);
        check("async_stall", 32'(stall_timeout), 32'd0);
        check("async_req0_ready", 32'(req0_ready), 32'd0);
        #2 rst_n = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 1'b1, OP_ADD, 32'd10, 32'd20, 1'b1, 1'b1);
        #1;
        check("post_rst_req0_ready", 32'(req0_ready), 32'd1);
        check("post_rst_req1_ready", 32'(req1_ready), 32'd0);
        check("post_rst_no_stale", 32'(rsp0_valid | rsp1_valid), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b1, 1'b1);
        check("post_rst_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("post_rst_result", rsp_result, 32'd3);

`ifdef ALU_SHARE_PERF_EN
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, OP_ADD, 32'd2, 32'd2, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b1, 1'b1);
        check("perf_grant0", perf_grant0, 32'd5);
        check("perf_grant1", perf_grant1, 32'd5);
        check("perf_conflict", perf_conflict, 32'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between two requesters (req0 = EXU integer path, req1 = branch/address unit) using valid/ready handshakes.
- Round-robin arbitration, one operation issued per cycle at most.
- Result is registered in a single response slot and returned on the owning requester's response channel with 1-cycle latency.

Parameters:
- WIDTH, 32, datapath width of operands/result; passed to the ALU instance.
- TIMEOUT_W, 8, width of per-slot hold counter (response-stall watchdog).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid / req1_valid  input  1  requester N presents an operation.
- req0_ready / req1_ready  output  1  operation accepted this cycle when valid&ready.
- req0_op / req1_op  input  4  ALU opcode (ALU encoding: 0000 add, 0001 sub, 1110 and, 1100 or, 1000 xor, 0010 sll, 1010 srl, 1011 sra, 0100 slt, 0110 sltu, other = pass right).
- req0_left / req1_left  input  WIDTH  left operand.
- req0_right / req1_right  input  WIDTH  right operand.
- rsp0_valid / rsp1_valid  output  1  result for requester N held in slot.
- rsp0_ready / rsp1_ready  input  1  requester N consumes the result.
- rsp_result  output  WIDTH  registered ALU result (shared bus, qualified by rspN_valid).
- rsp_zero  output  1  registered zero_flag of the add/sub path.
- stall_timeout  output  1  sticky; response slot held ≥ 2^TIMEOUT_W−1 cycles.

Behaviour:
- Reset (async, rst_n=0): slot state EMPTY, owner=0, rr_ptr=0 (req0 preferred first), rsp_result=0, rsp_zero=0, hold counter=0, stall_timeout=0. All ready/valid outputs 0 during reset.
- Slot FSM, two states:
  - EMPTY → FULL on grant.
  - FULL → EMPTY on rspN_valid & rspN_ready with no new grant.
  - FULL → FULL on drain with simultaneous grant (back-to-back, one op/cycle sustained).
- can_issue = (state==EMPTY) | (state==FULL & rsp_owner_valid & rsp_owner_ready).
- Arbitration (combinational):
  - Both valid: grant rr_ptr side.
  - One valid: grant it.
  - reqN_ready = can_issue & grantN; ready for non-granted side is 0.
  - reqN_ready may depend on reqN_valid; requesters must not make valid depend on ready.
- On grant: ALU computes from granted op/operands; rsp_result, rsp_zero, owner register on the same edge.
  - rsp valid asserted next cycle (latency 1).
  - rr_ptr <= ~granted side, updated only on grant.
- rspN_valid = (state==FULL) & (owner==N). Slot contents stable while FULL and not drained.
- Operand/op selection uses a single shared ALU; no speculative issue; unused requester inputs ignored.
- Hold counter:
  - Clears on every grant or drain.
  - Increments while FULL and not drained; saturates at all-ones.
  - Reaching all-ones sets stall_timeout (sticky until reset).
- Reset mid-operation discards slot contents; no response is delivered.

Optional Feature:
- ALU_SHARE_PERF_EN:
  - Defined: adds outputs perf_grant0, perf_grant1 (32 bit each, count grants per requester) and perf_conflict (32 bit, cycles with both valid and can_issue=1).
  - All three wrap modulo 2^32 and reset to 0 on rst_n.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then req0 add 5+7, rsp0_ready=1 → req0_ready=1 same cycle, next cycle rsp0_valid=1, rsp_result=12, rsp_zero=0, rsp1_valid=0.
- Both valid every cycle, rsp ready=1: req0 sub 3−3, req1 sltu 1<2 → grants alternate 0,1,0,1. First rsp_result=0 with rsp_zero=1, next rsp_result=1, one result per cycle.
- req1 sra 0x80000000>>>4 with rsp1_ready=0 for 3 cycles → rsp1_valid held, result 0xF8000000 stable. req0_ready=0 meanwhile; req0 granted in the cycle rsp1_ready=1.
- Hold rsp0_ready=0 for 255 cycles with TIMEOUT_W=8 → stall_timeout rises and stays 1 after the drain.
- Assert rst_n=0 while FULL → all outputs 0 immediately (async). After release, req0 first: rr_ptr=0, no stale response.
- With ALU_SHARE_PERF_EN, 10 conflicting cycles → perf_grant0=5, perf_grant1=5, perf_conflict=10.
